ws2812_frame_ctrl: RTL and testbench

Frame controller for the WS2812 LED output path. It holds a ping-pong pixel buffer written by the host. On command it streams one complete frame, one 24-bit GRB word per LED, to the WS2812 bit serializer over a valid/ready handshake. It then enforces the latch (reset) gap before reporting completion, so the serializer never sees a partial frame or a short gap.

---
 rtl/ws2812_frame_ctrl.sv | 130 +++++++++++++
 tb/tb_ws2812_frame_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_ctrl.sv
// ws2812_frame_ctrl: ping-pong pixel buffer that streams whole GRB frames to a WS2812 serializer
// and enforces the latch gap before signalling completion.
module ws2812_frame_ctrl #(
  parameter int LED_COUNT = 8,
  parameter int CLK_FRE   = 27_000_000,
  parameter int LATCH_US  = 80
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [7:0]  wr_addr,
  input  logic [23:0] wr_rgb,
  input  logic        commit,
  output logic        busy,
  output logic        pix_valid,
  output logic [23:0] pix_grb,
  input  logic        pix_ready,
  output logic        frame_last,
  output logic        done
);
  localparam int LATCH_RAW    = CLK_FRE / 1_000_000 * LATCH_US;
  localparam int LATCH_CYCLES = LATCH_RAW < 1 ? 1 : LATCH_RAW;
  localparam logic [7:0]  LAST_IDX = 8'(LED_COUNT - 1);
  localparam logic [31:0] CNT_END  = 32'(LATCH_CYCLES - 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SEND  = 2'd2;
  localparam logic [1:0] LATCH = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        front_q, front_d;
  logic        pending_q, pending_d;
  logic        pix_valid_q, pix_valid_d;
  logic        done_q, done_d;
  logic [7:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic [23:0] pix_grb_q, pix_grb_d;
  logic [23:0] cur_rgb;
  logic        restart;
  logic [23:0] bank_q [2][LED_COUNT];
  logic [23:0] bank_d [2][LED_COUNT];

  // Host writes always land in the back bank; the front bank feeds the serializer.
  always_comb begin
    bank_d = bank_q;
    cur_rgb = '0;
    for (int i = 0; i < LED_COUNT; i++) begin
      if (wr_en && wr_addr == 8'(i)) bank_d[~front_q][i] = wr_rgb;
      if (idx_q == 8'(i)) cur_rgb = bank_q[front_q][i];
    end
  end

  always_comb begin
    state_d     = state_q;
    front_d     = front_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    pix_valid_d = pix_valid_q;
    pix_grb_d   = pix_grb_q;
    done_d      = 1'b0;
    pending_d   = pending_q | (commit && state_q != IDLE);
    restart     = pending_q | commit;
    case (state_q)
      IDLE: begin
        if (commit) begin
          front_d = ~front_q;
          idx_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        pix_grb_d   = {cur_rgb[15:8], cur_rgb[23:16], cur_rgb[7:0]};
        pix_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (pix_ready) begin
          pix_valid_d = 1'b0;
          cnt_d       = '0;
          idx_d       = idx_q == LAST_IDX ? idx_q : idx_q + 8'd1;
          state_d     = idx_q == LAST_IDX ? LATCH : LOAD;
        end
      end
      default: begin
        // A commit arriving in the last gap cycle chains straight into the next frame.
        if (cnt_q == CNT_END) begin
          done_d    = 1'b1;
          pending_d = 1'b0;
          front_d   = restart ? ~front_q : front_q;
          idx_d     = '0;
          state_d   = restart ? LOAD : IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      front_q     <= 1'b0;
      pending_q   <= 1'b0;
      pix_valid_q <= 1'b0;
      done_q      <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      pix_grb_q   <= '0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < LED_COUNT; i++)
          bank_q[b][i] <= '0;
    end else begin
      state_q     <= state_d;
      front_q     <= front_d;
      pending_q   <= pending_d;
      pix_valid_q <= pix_valid_d;
      done_q      <= done_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      pix_grb_q   <= pix_grb_d;
      bank_q      <= bank_d;
    end
  end

  assign busy       = state_q != IDLE;
  assign pix_valid  = pix_valid_q;
  assign pix_grb    = pix_grb_q;
  assign done       = done_q;
  assign frame_last = pix_valid_q && idx_q == LAST_IDX;
endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// tb_ws2812_frame_ctrl: directed bench for ws2812_frame_ctrl with LED_COUNT=3 and a 5-cycle latch gap.
module tb_ws2812_frame_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [23:0] wr_rgb = '0;
  logic        commit = 1'b0;
  logic        pix_ready = 1'b0;
  logic        busy, pix_valid, frame_last, done;
  logic [23:0] pix_grb;
  int errors = 0;
  int checks = 0;

  ws2812_frame_ctrl #(.LED_COUNT(3), .CLK_FRE(1_000_000), .LATCH_US(5)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_rgb(wr_rgb),
    .commit(commit), .busy(busy), .pix_valid(pix_valid), .pix_grb(pix_grb),
    .pix_ready(pix_ready), .frame_last(frame_last), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = a; wr_rgb = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic get_pix(input int stall, input logic [23:0] exp, input logic last, input string tag);
    int n = 0;
    while (pix_valid !== 1'b1 && n < 50) begin tick(); n++; end
    chk({tag, "_valid"}, 32'(pix_valid), 32'd1);
    for (int s = 0; s < stall; s++) begin
      chk({tag, "_hold"}, 32'(pix_grb), 32'(exp));
      tick();
      chk({tag, "_hold_valid"}, 32'(pix_valid), 32'd1);
    end
    chk({tag, "_grb"}, 32'(pix_grb), 32'(exp));
    chk({tag, "_last"}, 32'(frame_last), 32'(last));
    pix_ready = 1'b1;
    tick();
    chk({tag, "_hs"}, 32'(pix_valid), 32'd0);
    if (stall > 0) pix_ready = 1'b0;
  endtask

  task automatic latch_end(input logic restart, input string tag);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk({tag, "_gap"}, 32'(done), 32'd0);
    end
    tick();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'(restart));
    chk({tag, "_done_valid"}, 32'(pix_valid), 32'd0);
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_next_valid"}, 32'(pix_valid), 32'(restart));
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_last", 32'(frame_last), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_grb", 32'(pix_grb), 32'd0);
    reset_n = 1'b1;
    tick();
    // basic frame
    wr(8'd0, 24'hFF0000);
    wr(8'd1, 24'h00FF00);
    wr(8'd2, 24'h0000FF);
    pix_ready = 1'b1;
    do_commit();
    chk("basic_busy", 32'(busy), 32'd1);
    get_pix(0, 24'h00FF00, 1'b0, "basic0");
    get_pix(0, 24'hFF0000, 1'b0, "basic1");
    get_pix(0, 24'h0000FF, 1'b1, "basic2");
    latch_end(1'b0, "basic");
    // backpressure
    wr(8'd0, 24'h112233);
    wr(8'd1, 24'h445566);
    wr(8'd2, 24'h778899);
    pix_ready = 1'b0;
    do_commit();
    get_pix(10, 24'h221133, 1'b0, "bp0");
    get_pix(10, 24'h554466, 1'b0, "bp1");
    get_pix(10, 24'h887799, 1'b1, "bp2");
    latch_end(1'b0, "bp");
    // ping-pong isolation with a pending frame
    pix_ready = 1'b1;
    do_commit();
    wr_en = 1'b1; wr_addr = 8'd0; wr_rgb = 24'h123456; commit = 1'b1;
    tick();
    wr_en = 1'b0; commit = 1'b0;
    get_pix(0, 24'h00FF00, 1'b0, "pp_a0");
    get_pix(0, 24'hFF0000, 1'b0, "pp_a1");
    get_pix(0, 24'h0000FF, 1'b1, "pp_a2");
    latch_end(1'b1, "pp_a");
    get_pix(0, 24'h341256, 1'b0, "pp_b0");
    get_pix(0, 24'h554466, 1'b0, "pp_b1");
    get_pix(0, 24'h887799, 1'b1, "pp_b2");
    latch_end(1'b0, "pp_b");
    // coalescing and out-of-range write
    do_commit();
    wr_en = 1'b1; wr_addr = 8'd3; wr_rgb = 24'hFFFFFF; commit = 1'b1;
    tick();
    wr_en = 1'b0; commit = 1'b0;
    get_pix(0, 24'h00FF00, 1'b0, "co_a0");
    pix_ready = 1'b0; commit = 1'b1;
    tick();
    tick();
    commit = 1'b0;
    get_pix(0, 24'hFF0000, 1'b0, "co_a1");
    get_pix(0, 24'h0000FF, 1'b1, "co_a2");
    latch_end(1'b1, "co_a");
    get_pix(0, 24'h341256, 1'b0, "co_b0");
    get_pix(0, 24'h554466, 1'b0, "co_b1");
    get_pix(0, 24'h887799, 1'b1, "co_b2");
    latch_end(1'b0, "co_b");
    tick();
    tick();
    chk("co_idle_busy", 32'(busy), 32'd0);
    chk("co_idle_valid", 32'(pix_valid), 32'd0);
    // same-cycle write and commit in IDLE
    wr_en = 1'b1; wr_addr = 8'd2; wr_rgb = 24'hABCDEF; commit = 1'b1;
    tick();
    wr_en = 1'b0; commit = 1'b0;
    get_pix(0, 24'h00FF00, 1'b0, "sc0");
    get_pix(0, 24'hFF0000, 1'b0, "sc1");
    get_pix(0, 24'hCDABEF, 1'b1, "sc2");
    latch_end(1'b0, "sc");
    // reset in the middle of the second pixel
    do_commit();
    get_pix(0, 24'h341256, 1'b0, "rm0");
    pix_ready = 1'b0;
    tick();
    chk("rm1_valid", 32'(pix_valid), 32'd1);
    chk("rm1_grb", 32'(pix_grb), 32'h554466);
    reset_n = 1'b0;
    #2;
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_valid", 32'(pix_valid), 32'd0);
    chk("rm_grb", 32'(pix_grb), 32'd0);
    chk("rm_last", 32'(frame_last), 32'd0);
    chk("rm_done", 32'(done), 32'd0);
    tick();
    reset_n = 1'b1;
    pix_ready = 1'b1;
    tick();
    do_commit();
    get_pix(0, 24'h000000, 1'b0, "rz0");
    get_pix(0, 24'h000000, 1'b0, "rz1");
    get_pix(0, 24'h000000, 1'b1, "rz2");
    latch_end(1'b0, "rz");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
